fpu_operand_queue: RTL and testbench

- Upstream operand-staging stage for the FP sign/exception merge stage.
- Buffers 32-bit operand pairs (opa, opb) plus the per-op fast flag in a small circular FIFO.
- Presents one pair per cycle to the merge stage via valid/ready.
- Also precomputes head-entry classification bits (sign, exponent-all-ones) so the merge stage can consume them without recomputing.

---
 rtl/fpu_pkg.sv | 22 ++
 rtl/fpu_operand_classify.sv | 29 ++
 rtl/fpu_operand_queue.sv | 100 ++++++++++
 tb/tb_fpu_operand_queue.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared FP operand definitions: default width, field positions, pair type
// and the exponent classification helper used by the operand stages.
package fpu_pkg;

  localparam int FPU_WIDTH = 32;
  localparam int SIGN_BIT  = FPU_WIDTH - 1;
  localparam int EXP_HI    = FPU_WIDTH - 2;
  localparam int EXP_LO    = FPU_WIDTH - 9;
  localparam int EXP_W     = EXP_HI - EXP_LO + 1;

  typedef struct packed {
    logic [FPU_WIDTH-1:0] opa;
    logic [FPU_WIDTH-1:0] opb;
    logic                 fast;
  } operand_pair_t;

  // True when the exponent field is all ones (Inf/NaN encodings).
  function automatic logic exp_all_ones(input logic [FPU_WIDTH-1:0] word);
    return &word[EXP_HI:EXP_LO];
  endfunction

endpackage

// File: rtl/fpu_operand_classify.sv
// Combinational classification of an operand pair: signs and whether either
// operand carries an all-ones exponent. Shared with the merge stage.
module fpu_operand_classify
  import fpu_pkg::*;
#(
  parameter int WIDTH = FPU_WIDTH
) (
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             sign_a,
  output logic             sign_b,
  output logic             exp_max
);

  assign sign_a = opa[WIDTH-1];
  assign sign_b = opb[WIDTH-1];

  generate
    if (WIDTH == FPU_WIDTH) begin : g_pkg_fmt
      assign exp_max = exp_all_ones(opa) | exp_all_ones(opb);
    end else begin : g_gen_fmt
      // Non-default width: exponent still sits directly under the sign bit.
      logic unused_mant;
      assign exp_max     = (&opa[WIDTH-2 -: EXP_W]) | (&opb[WIDTH-2 -: EXP_W]);
      assign unused_mant = ^{opa[WIDTH-EXP_W-2:0], opb[WIDTH-EXP_W-2:0]};
    end
  endgenerate

endmodule

// File: rtl/fpu_operand_queue.sv
// Operand staging FIFO in front of the FP sign/exception merge stage.
// Circular buffer of (opa, opb, fast) with registered occupancy; head data
// and its classification are presented combinationally and zeroed when empty.
module fpu_operand_queue
  import fpu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = FPU_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_opa,
  input  logic [WIDTH-1:0]         in_opb,
  input  logic                     in_fast,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         opa,
  output logic [WIDTH-1:0]         opb,
  output logic                     fast,
  output logic                     sign_a,
  output logic                     sign_b,
  output logic                     exp_max,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [DEPTH-1:0] mem_f;

  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count;
  logic          full, empty, push, pop;

  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = ~full;
  assign out_valid = ~empty;
  assign level     = count;

  // Flush squashes both handshakes so neither storage nor pointers move.
  assign push = in_valid & ~full & ~flush;
  assign pop  = out_ready & ~empty & ~flush;

  // Storage is data-only and never reset; validity lives in count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= in_opa;
      mem_b[wr_ptr] <= in_opb;
      mem_f[wr_ptr] <= in_fast;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH (power of two).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Head view gated by validity so stale storage never leaks downstream.
  always_comb begin
    opa  = '0;
    opb  = '0;
    fast = 1'b0;
    if (out_valid) begin
      opa  = mem_a[rd_ptr];
      opb  = mem_b[rd_ptr];
      fast = mem_f[rd_ptr];
    end
  end

  fpu_operand_classify #(.WIDTH(WIDTH)) u_classify (
    .opa     (opa),
    .opb     (opb),
    .sign_a  (sign_a),
    .sign_b  (sign_b),
    .exp_max (exp_max)
  );

endmodule

// File: tb/tb_fpu_operand_queue.sv
// Scoreboard bench for fpu_operand_queue: accepted pushes are queued as
// expected pairs, and every pop seen at the falling edge is compared to the
// oldest one, including sign/exponent classification derived here.
module tb_fpu_operand_queue;
  import fpu_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_opa = '0;
  logic [WIDTH-1:0] in_opb = '0;
  logic             in_fast = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] opa, opb;
  logic             fast, sign_a, sign_b, exp_max;
  logic [$clog2(DEPTH):0] level;

  int n_chk = 0;
  int n_err = 0;
  bit seen_dead = 1'b0;
  operand_pair_t sb[$];

  fpu_operand_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opa(in_opa), .in_opb(in_opb), .in_fast(in_fast),
    .out_valid(out_valid), .out_ready(out_ready),
    .opa(opa), .opb(opb), .fast(fast),
    .sign_a(sign_a), .sign_b(sign_b), .exp_max(exp_max),
    .level(level)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic emax(input logic [31:0] w);
    return (w[30:23] == 8'hFF);
  endfunction

  // Scoreboard: compare pops against the oldest expected pair, then record accepted pushes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (flush) begin
        sb.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (opa == 32'hDEAD_BEEF) seen_dead = 1'b1;
          if (sb.size() == 0) begin
            chk("unexpected_pop", 64'(opa), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            operand_pair_t e;
            e = sb.pop_front();
            chk("pop_opa", 64'(opa), 64'(e.opa));
            chk("pop_opb", 64'(opb), 64'(e.opb));
            chk("pop_fast", 64'(fast), 64'(e.fast));
            chk("pop_sign_a", 64'(sign_a), 64'(e.opa[31]));
            chk("pop_sign_b", 64'(sign_b), 64'(e.opb[31]));
            chk("pop_exp_max", 64'(exp_max), 64'(emax(e.opa) | emax(e.opb)));
          end
        end
        if (in_valid && in_ready) sb.push_back('{opa: in_opa, opb: in_opb, fast: in_fast});
      end
    end
  end

  always @(negedge rst_n) sb.delete();

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic f);
    in_valid = 1'b1;
    in_opa   = a;
    in_opb   = b;
    in_fast  = f;
  endtask

  task automatic push1(input logic [31:0] a, input logic [31:0] b, input logic f);
    drive(a, b, f);
    step();
    in_valid = 1'b0;
  endtask

  // Pop until empty, bounded; an expired bound is a failed check.
  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (out_valid && n < 20) begin
      step();
      n++;
    end
    out_ready = 1'b0;
    chk("drain_done", 64'(out_valid), 64'd0);
    chk("drain_sb_empty", 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_opa_zero", 64'(opa), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // Single push, one-cycle latency
    push1(32'h8000_0001, 32'h4000_0000, 1'b1);
    chk("t1_out_valid", 64'(out_valid), 64'd1);
    chk("t1_sign_a", 64'(sign_a), 64'd1);
    chk("t1_sign_b", 64'(sign_b), 64'd0);
    chk("t1_exp_max", 64'(exp_max), 64'd0);
    chk("t1_fast", 64'(fast), 64'd1);
    chk("t1_level", 64'(level), 64'd1);
    drain();

    // Fill to full, dropped push while full, ordered drain
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000_0000 + 32'(i), 32'h2000_0000 + 32'(i), i[0]);
      step();
    end
    in_valid = 1'b0;
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    chk("t2_level_full", 64'(level), 64'd4);
    push1(32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1);
    chk("t2_level_after_drop", 64'(level), 64'd4);
    drain();
    chk("t2_no_deadbeef", 64'(seen_dead), 64'd0);

    // Steady push+pop across pointer wrap
    for (int i = 0; i < 3; i++) push1(32'h3000_0000 + 32'(i), 32'hB000_0000 + 32'(i), 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(32'h3100_0000 + 32'(i), 32'hB100_0000 + 32'(i), i[1]);
      step();
      chk("t3_level_steady", 64'(level), 64'd3);
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    drain();

    // Classification boundaries
    push1(32'h7F80_0000, 32'h0000_0000, 1'b0);
    chk("t4_inf_exp_max", 64'(exp_max), 64'd1);
    chk("t4_inf_sign_a", 64'(sign_a), 64'd0);
    drain();
    push1(32'h0000_0000, 32'hFF80_0001, 1'b0);
    chk("t4_nan_exp_max", 64'(exp_max), 64'd1);
    chk("t4_nan_sign_b", 64'(sign_b), 64'd1);
    drain();
    push1(32'h7F00_0000, 32'h0000_0000, 1'b0);
    chk("t4_big_exp_max", 64'(exp_max), 64'd0);
    drain();

    // Flush overrides simultaneous push and pop
    push1(32'h4400_0001, 32'h4400_0002, 1'b0);
    push1(32'h4400_0003, 32'h4400_0004, 1'b1);
    chk("t5_level_pre", 64'(level), 64'd2);
    drive(32'h1111_1111, 32'h2222_2222, 1'b1);
    out_ready = 1'b1;
    flush     = 1'b1;
    step();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("t5_level_flushed", 64'(level), 64'd0);
    chk("t5_out_valid_flushed", 64'(out_valid), 64'd0);
    chk("t5_opa_gated", 64'(opa), 64'd0);
    push1(32'h5555_0001, 32'h5555_0002, 1'b1);
    chk("t5_sole_level", 64'(level), 64'd1);
    chk("t5_sole_opa", 64'(opa), 64'h5555_0001);
    drain();

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) push1(32'h6600_0000 + 32'(i), 32'h0, 1'b0);
    chk("t6_level_pre", 64'(level), 64'd3);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_out_valid_async", 64'(out_valid), 64'd0);
    chk("t6_in_ready_async", 64'(in_ready), 64'd1);
    chk("t6_level_async", 64'(level), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("t6_empty_after", 64'(out_valid), 64'd0);
    push1(32'h7700_0001, 32'h7700_0002, 1'b0);
    chk("t6_level_after", 64'(level), 64'd1);
    chk("t6_opa_after", 64'(opa), 64'h7700_0001);
    drain();

    step();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
